// File: rtl/tinker_pkg.sv
// Shared register-file geometry and the writeback request record used by the
// writeback arbiter and its busy scoreboard.
package tinker_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 64;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write scoreboard: decode reserves a destination, the
// accepted writeback releases it. Register 0 is tracked like any other.
module wb_scoreboard
  import tinker_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_rd_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_rd_i,
  output logic [NUM_REGS-1:0]   busy_o
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Clear is applied first so a reservation on the same edge wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_rd_i] = 1'b0;
    if (set_en_i) busy_d[set_rd_i] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_o = busy_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source (ALU / load) register-file writeback arbiter with aging and a
// busy scoreboard. Define WB_CONFLICT_CNT_EN to add the conflict_cnt output.
module regfile_wb_arbiter
  import tinker_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  input  logic                  resv_valid,
  input  logic [REG_ADDR_W-1:0] resv_rd,
  output logic                  rf_write_enable,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0]     rf_write_data,
`ifdef WB_CONFLICT_CNT_EN
  output logic [31:0]           conflict_cnt,
`endif
  output logic [NUM_REGS-1:0]   busy
);

  localparam logic [3:0] AGE_MAX = 4'(STARVE_MAX);

  logic [3:0]            age_q, age_d;
  logic                  starved, alu_grant, mem_grant, hs;
  wb_req_t               win;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_addr_q;
  logic [DATA_W-1:0]     rf_data_q;

  // Handshake: a source transfers when its valid and ready are both high at a
  // rising edge; ready is a pure decode of the valids and age, never high
  // without its own valid, never both high, and low throughout reset.
  assign starved   = (age_q == AGE_MAX);
  assign alu_grant = reset_n && alu_valid && (!mem_valid || starved);
  assign mem_grant = reset_n && mem_valid && !alu_grant;
  assign hs        = alu_grant || mem_grant;
  assign alu_ready = alu_grant;
  assign mem_ready = mem_grant;

  always_comb begin
    win = alu_grant ? wb_req_t'{rd: alu_rd, data: alu_data}
                    : wb_req_t'{rd: mem_rd, data: mem_data};
  end

  // Age counts ALU losses and saturates; any ALU win or idle cycle resets it.
  always_comb begin
    age_d = age_q;
    if (!alu_valid || alu_grant) age_d = '0;
    else if (!starved)           age_d = age_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age_q     <= '0;
      rf_we_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
    end else begin
      age_q   <= age_d;
      rf_we_q <= hs;
      if (hs) begin
        rf_addr_q <= win.rd;
        rf_data_q <= win.data;
      end
    end
  end

  assign rf_write_enable = rf_we_q;
  assign rf_rd_addr      = rf_addr_q;
  assign rf_write_data   = rf_data_q;

`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conflict_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    conflict_q <= '0;
    else if (alu_valid && mem_valid) conflict_q <= conflict_q + 32'd1;
  end

  assign conflict_cnt = conflict_q;
`endif

  wb_scoreboard u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .set_en_i (resv_valid),
    .set_rd_i (resv_rd),
    .clr_en_i (hs),
    .clr_rd_i (win.rd),
    .busy_o   (busy)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: a reference arbitration/busy
// model feeds an expected-write queue that is drained against the RF port.
module tb_regfile_wb_arbiter;

  localparam int STARVE = 4;
  localparam int W      = 69;

  logic        clk;
  logic        reset_n;
  logic        alu_valid, mem_valid, resv_valid;
  logic [4:0]  alu_rd, mem_rd, resv_rd;
  logic [63:0] alu_data, mem_data;
  logic        alu_ready, mem_ready;
  logic        rf_write_enable;
  logic [4:0]  rf_rd_addr;
  logic [63:0] rf_write_data;
  logic [31:0] busy;
`ifdef WB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt;
`endif

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_e;
  logic [31:0]  m_busy;
  int           m_age;
  int           m_conf;
  int           cmp_cnt;
  int           fail_cnt;

  regfile_wb_arbiter #(.STARVE_MAX(STARVE)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_rd          (mem_rd),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .resv_valid      (resv_valid),
    .resv_rd         (resv_rd),
    .rf_write_enable (rf_write_enable),
    .rf_rd_addr      (rf_rd_addr),
    .rf_write_data   (rf_write_data),
`ifdef WB_CONFLICT_CNT_EN
    .conflict_cnt    (conflict_cnt),
`endif
    .busy            (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_age  = 0;
    m_busy = '0;
    m_conf = 0;
    last_e = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [63:0] md,
                       input logic rv, input logic [4:0] rrd);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    resv_valid = rv; resv_rd = rrd;
  endtask

  task automatic drive_idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
  endtask

  // One clock of the scoreboard: predict grant, push expected write, advance
  // the model, then pop and compare the registered write port and busy.
  task automatic step();
    logic         exp_alu, exp_mem;
    logic [W-1:0] e;
    #1;
    exp_alu = alu_valid && (!mem_valid || m_age == STARVE);
    exp_mem = mem_valid && !exp_alu;
    cmp_cnt++;
    if ({alu_ready, mem_ready} !== {exp_alu, exp_mem}) begin
      fail_cnt++;
      $display("FAIL ready_decode: got alu=%b mem=%b want alu=%b mem=%b",
               alu_ready, mem_ready, exp_alu, exp_mem);
    end
    if (exp_alu)      exp_q.push_back({alu_rd, alu_data});
    else if (exp_mem) exp_q.push_back({mem_rd, mem_data});
    if (alu_valid && mem_valid) m_conf++;
    if (!alu_valid || exp_alu) m_age = 0;
    else if (m_age < STARVE)   m_age++;
    if (exp_alu) m_busy[alu_rd] = 1'b0;
    if (exp_mem) m_busy[mem_rd] = 1'b0;
    if (resv_valid) m_busy[resv_rd] = 1'b1;
    @(posedge clk);
    #1;
    if (exp_alu || exp_mem) begin
      e = exp_q.pop_front();
      last_e = e;
      cmp_cnt++;
      if (rf_write_enable !== 1'b1 || {rf_rd_addr, rf_write_data} !== e) begin
        fail_cnt++;
        $display("FAIL rf_write: got we=%b rd=%0d data=%h want we=1 rd=%0d data=%h",
                 rf_write_enable, rf_rd_addr, rf_write_data, e[68:64], e[63:0]);
      end
    end else begin
      cmp_cnt++;
      if (rf_write_enable !== 1'b0 || {rf_rd_addr, rf_write_data} !== last_e) begin
        fail_cnt++;
        $display("FAIL rf_idle_hold: got we=%b rd=%0d data=%h want we=0 rd=%0d data=%h",
                 rf_write_enable, rf_rd_addr, rf_write_data, last_e[68:64], last_e[63:0]);
      end
    end
    cmp_cnt++;
    if (busy !== m_busy) begin
      fail_cnt++;
      $display("FAIL busy: got %h want %h", busy, m_busy);
    end
`ifdef WB_CONFLICT_CNT_EN
    cmp_cnt++;
    if (conflict_cnt !== m_conf) begin
      fail_cnt++;
      $display("FAIL conflict_cnt: got %0d want %0d", conflict_cnt, m_conf);
    end
`endif
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 5'd1, 64'h11, 1'b1, 5'd2, 64'h22, 1'b1, 5'd3);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp_cnt++;
    if ({alu_ready, mem_ready, rf_write_enable} !== 3'b000 || busy !== 32'd0 ||
        rf_rd_addr !== 5'd0 || rf_write_data !== 64'd0) begin
      fail_cnt++;
      $display("FAIL reset_state: got rdy=%b%b we=%b busy=%h rd=%0d data=%h want all 0",
               alu_ready, mem_ready, rf_write_enable, busy, rf_rd_addr, rf_write_data);
    end
    drive_idle();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single_mem();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 64'hDEAD, 1'b0, 5'd0);
    step();
    cmp_cnt++;
    if (rf_write_enable !== 1'b1 || rf_rd_addr !== 5'd3 || rf_write_data !== 64'hDEAD) begin
      fail_cnt++;
      $display("FAIL single_mem: got we=%b rd=%0d data=%h want we=1 rd=3 data=dead",
               rf_write_enable, rf_rd_addr, rf_write_data);
    end
    drive_idle();
    step();
    cmp_cnt++;
    if (rf_write_enable !== 1'b0) begin
      fail_cnt++;
      $display("FAIL single_mem_off: got we=%b want 0", rf_write_enable);
    end
  endtask

  task automatic test_reserve_clear();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd7);
    step();
    drive_idle();
    step();
    cmp_cnt++;
    if (busy[7] !== 1'b1) begin
      fail_cnt++;
      $display("FAIL reserve_hold: got busy[7]=%b want 1", busy[7]);
    end
    drive(1'b1, 5'd7, 64'h7777, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    step();
    cmp_cnt++;
    if (busy[7] !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reserve_clear: got busy[7]=%b want 0", busy[7]);
    end
    drive(1'b1, 5'd0, 64'h0F0F, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    step();
    drive_idle();
    step();
  endtask

  task automatic test_set_wins();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9);
    step();
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h9999, 1'b1, 5'd9);
    step();
    cmp_cnt++;
    if (busy[9] !== 1'b1) begin
      fail_cnt++;
      $display("FAIL set_wins: got busy[9]=%b want 1", busy[9]);
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd12);
    step();
    drive(1'b1, 5'd4, 64'h4444, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0);
    #1;
    cmp_cnt++;
    if (alu_ready !== 1'b1) begin
      fail_cnt++;
      $display("FAIL mid_pre_ready: got alu_ready=%b want 1", alu_ready);
    end
    #1;
    reset_n = 1'b0;
    #1;
    cmp_cnt++;
    if ({alu_ready, mem_ready} !== 2'b00 || busy !== 32'd0) begin
      fail_cnt++;
      $display("FAIL mid_reset: got rdy=%b%b busy=%h want rdy=00 busy=0",
               alu_ready, mem_ready, busy);
    end
    @(posedge clk);
    #1;
    cmp_cnt++;
    if (rf_write_enable !== 1'b0) begin
      fail_cnt++;
      $display("FAIL mid_no_write: got we=%b want 0", rf_write_enable);
    end
    drive_idle();
    model_reset();
    reset_n = 1'b1;
    step();
    step();
  endtask

`ifdef WB_CONFLICT_CNT_EN
  task automatic test_conflict();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'd20, 64'hA0 + i, 1'b1, 5'd21, 64'hB0 + i, 1'b0, 5'd0);
      step();
    end
    drive_idle();
    step();
    cmp_cnt++;
    if (conflict_cnt !== 32'd6) begin
      fail_cnt++;
      $display("FAIL conflict_six: got %0d want 6", conflict_cnt);
    end
  endtask
`endif

  task automatic test_starve();
    drive_idle();
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 5'd1, 64'hA000 + i, 1'b1, 5'd2, 64'hB000 + i, 1'b0, 5'd0);
      #1;
      cmp_cnt++;
      if (alu_ready !== (i == 4) || mem_ready !== (i != 4)) begin
        fail_cnt++;
        $display("FAIL starve_cycle%0d: got alu=%b mem=%b want alu=%b mem=%b",
                 i, alu_ready, mem_ready, (i == 4), (i != 4));
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      step();
    end
    drive_idle();
    step();
  endtask

  initial begin
    cmp_cnt  = 0;
    fail_cnt = 0;
    reset_n  = 1'b0;
    drive_idle();
    test_reset();
    test_single_mem();
    test_reserve_clear();
    test_set_wins();
    test_reset_mid();
`ifdef WB_CONFLICT_CNT_EN
    test_conflict();
`endif
    test_starve();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
